// File: rtl/uart_pkg.sv
// Purpose: types and defaults shared by the UART receive and transmit blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int unsigned UART_CLKS_PER_BIT_DEF = 16;
  localparam logic [7:0]  UART_CMD_BYTE_DEF     = 8'hA5;

  // Parity bit a transmitter would send for this data. Zero-extension of
  // narrower data does not change the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input parity_e mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchroniser for a single asynchronous input.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none; free-running.
// Ports: clk_i clock, resetn_i async active-low reset, d_i async input,
//        q_o synchronised output (both flops reset to RST_VAL).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) sync_q <= {2{RST_VAL}};
    else           sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_cmd.sv
// Purpose: UART receiver (configurable frame) with error flags, break detect
//          and a reset-command detector producing a one-cycle strobe.
// Latency: rx_valid one cycle after the last stop sample (rxd sync adds 2 cycles).
// Backpressure: none; rx_valid is a pulse and must be consumed when seen.
// Ports: clk_i, resetn_i (async active-low), rxd_i (async, idle high),
//        rx_en_i (hold FSM in IDLE when low); rx_data_o, rx_valid_o,
//        parity_err_o, frame_err_o, break_det_o, reset_cmd_strobe_o, busy_o.
module uart_rx_cmd
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter logic [7:0]  CMD_BYTE     = UART_CMD_BYTE_DEF,
  parameter int unsigned CMD_COUNT    = 3
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 rxd_i,
  input  logic                 rx_en_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_det_o,
  output logic                 reset_cmd_strobe_o,
  output logic                 busy_o
);

  localparam int unsigned     CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  // IDLE sees the synchronised fall one cycle after it happens and spends one
  // more cycle entering START, so the half-bit count is shortened by two.
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CLKS_PER_BIT / 2 - 2);
  localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic             LAST_STOP  = 1'(STOP_BITS - 1);
  localparam logic [3:0]       CMD_LAST   = 4'(CMD_COUNT - 1);
  localparam parity_e          PAR        = parity_e'(2'(PARITY_MODE));

  logic rxd_s;

  sync_2ff #(.RST_VAL(1'b1)) u_rxd_sync (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .d_i      (rxd_i),
    .q_o      (rxd_s)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;     // parity error of frame in flight
  logic                 pbit_q, pbit_d;     // sampled parity bit (0 if none)
  logic                 stop_q, stop_d;     // index of next stop sample
  logic                 armed_q, armed_d;   // line seen high since last low stop
  logic [3:0]           cmd_q, cmd_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 brk_q, brk_d;
  logic                 strb_q, strb_d;
  logic                 tick, done, good;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    pbit_d    = pbit_q;
    stop_d    = stop_q;
    armed_d   = armed_q | rxd_s;
    cmd_d     = cmd_q;
    data_d    = data_q;
    vld_d     = 1'b0;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    brk_d     = 1'b0;
    strb_d    = 1'b0;
    tick      = (cnt_q == '0);
    done      = 1'b0;
    good      = 1'b0;

    if (state_q != ST_IDLE) cnt_d = tick ? CNT_RELOAD : cnt_q - 1'b1;

    if (!rx_en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A line still low after a bad stop bit is not a new start bit.
          if (!rxd_s && armed_q) begin
            state_d = ST_START;
            cnt_d   = CNT_HALF;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rxd_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              bit_d   = '0;
              perr_d  = 1'b0;
              pbit_d  = 1'b0;
              stop_d  = 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) state_d = (PAR != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (tick) begin
            pbit_d  = rxd_s;
            perr_d  = (rxd_s != parity_bit(8'(shift_q), PAR));
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (!rxd_s || (stop_q == LAST_STOP)) done   = 1'b1;
            else                                 stop_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (done) begin
      state_d   = ST_IDLE;
      armed_d   = rxd_s;
      vld_d     = 1'b1;
      data_d    = shift_q;
      par_err_d = perr_q;
      frm_err_d = !rxd_s;
      brk_d     = !rxd_s && (shift_q == '0) && !pbit_q;
      good      = !perr_q && rxd_s && (8'(shift_q) == CMD_BYTE);
      if (good && (cmd_q == CMD_LAST)) begin
        strb_d = 1'b1;
        cmd_d  = '0;
      end else if (good) begin
        cmd_d  = cmd_q + 1'b1;
      end else begin
        cmd_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      pbit_q    <= 1'b0;
      stop_q    <= 1'b0;
      armed_q   <= 1'b1;
      cmd_q     <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      brk_q     <= 1'b0;
      strb_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      pbit_q    <= pbit_d;
      stop_q    <= stop_d;
      armed_q   <= armed_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      brk_q     <= brk_d;
      strb_q    <= strb_d;
    end
  end

  assign rx_data_o          = data_q;
  assign rx_valid_o         = vld_q;
  assign parity_err_o       = par_err_q;
  assign frame_err_o        = frm_err_q;
  assign break_det_o        = brk_q;
  assign reset_cmd_strobe_o = strb_q;
  assign busy_o             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cmd.sv
module tb_uart_rx_cmd;

  localparam int CPB     = 4;
  localparam int EXP_LAT = 2 + CPB / 2 + 9 * CPB;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    logic       strb;
  } cap_t;

  logic clk = 1'b0;
  logic resetn;
  logic rxd_a, en_a, rxd_b, en_b;
  logic [7:0] dat_a;
  logic [6:0] dat_b;
  logic vld_a, perr_a, ferr_a, brk_a, strb_a, busy_a;
  logic vld_b, perr_b, ferr_b, brk_b, strb_b, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int stray   = 0;
  int cmd_cnt [2];
  cap_t cap_a[$];
  cap_t cap_b[$];

  always #5 clk = ~clk;

  // DUT a: 8N1, command 0xA5 x3.  DUT b: 7E2, command 0x3C x2.
  uart_rx_cmd #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
                .CMD_BYTE(8'hA5), .CMD_COUNT(3)) dut_a (
    .clk_i(clk), .resetn_i(resetn), .rxd_i(rxd_a), .rx_en_i(en_a),
    .rx_data_o(dat_a), .rx_valid_o(vld_a), .parity_err_o(perr_a), .frame_err_o(ferr_a),
    .break_det_o(brk_a), .reset_cmd_strobe_o(strb_a), .busy_o(busy_a));

  uart_rx_cmd #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2),
                .CMD_BYTE(8'h3C), .CMD_COUNT(2)) dut_b (
    .clk_i(clk), .resetn_i(resetn), .rxd_i(rxd_b), .rx_en_i(en_b),
    .rx_data_o(dat_b), .rx_valid_o(vld_b), .parity_err_o(perr_b), .frame_err_o(ferr_b),
    .break_det_o(brk_b), .reset_cmd_strobe_o(strb_b), .busy_o(busy_b));

  always @(negedge clk) begin
    if (vld_a) cap_a.push_back('{data: dat_a, perr: perr_a, ferr: ferr_a, brk: brk_a, strb: strb_a});
    if (vld_b) cap_b.push_back('{data: {1'b0, dat_b}, perr: perr_b, ferr: ferr_b, brk: brk_b, strb: strb_b});
    if (!vld_a && (strb_a || brk_a)) stray++;
    if (!vld_b && (strb_b || brk_b)) stray++;
  end

  task automatic drive(input int which, input logic v);
    if (which == 0) rxd_a = v;
    else            rxd_b = v;
  endtask

  // Serial frame: start, data LSB first, [parity], stop(s); then line high.
  task automatic send(input int which, input logic [7:0] data, input logic pbit,
                      input logic s0, input logic s1);
    logic [15:0] bits;
    int n;
    int nd;
    nd = (which == 0) ? 8 : 7;
    bits = '0;
    for (int i = 0; i < nd; i++) bits[1 + i] = data[i];
    n = 1 + nd;
    if (which == 1) begin bits[n] = pbit; n = n + 1; end
    bits[n] = s0; n = n + 1;
    if (which == 1) begin bits[n] = s1; n = n + 1; end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(which, bits[i]);
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    drive(which, 1'b1);
  endtask

  // Expected frame outcome straight from the frame rules.
  task automatic model_frame(input int which, input logic [7:0] data, input logic pbit,
                             input logic s0, input logic s1, output cap_t e);
    logic [7:0] d;
    bit haspar;
    bit good;
    d      = (which == 0) ? data : (data & 8'h7F);
    haspar = (which == 1);
    e.data = d;
    e.perr = haspar && (pbit != (^d));
    e.ferr = !s0 || (haspar && !s1);
    e.brk  = (d == 8'h00) && (!haspar || !pbit) && !s0;
    e.strb = 1'b0;
    good   = !e.perr && !e.ferr && (d == ((which == 0) ? 8'hA5 : 8'h3C));
    if (good) begin
      cmd_cnt[which] = cmd_cnt[which] + 1;
      if (cmd_cnt[which] == ((which == 0) ? 3 : 2)) begin
        e.strb = 1'b1;
        cmd_cnt[which] = 0;
      end
    end else begin
      cmd_cnt[which] = 0;
    end
  endtask

  // Waits (bounded) for a captured frame; returns all-X on timeout.
  task automatic get_cap(input int which, output cap_t c);
    bit got;
    got = 0;
    c = 'x;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (which == 0 && cap_a.size() > 0)      begin c = cap_a.pop_front(); got = 1; end
      else if (which == 1 && cap_b.size() > 0) begin c = cap_b.pop_front(); got = 1; end
    end
  endtask

  task automatic do_frame(input int which, input logic [7:0] data, input logic pbit,
                          input logic s0, input logic s1, output cap_t got, output cap_t exp);
    send(which, data, pbit, s0, s1);
    model_frame(which, data, pbit, s0, s1, exp);
    get_cap(which, got);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; rxd_a = 1'b1; rxd_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    cmd_cnt[0] = 0; cmd_cnt[1] = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({dat_a, vld_a, perr_a, ferr_a, brk_a, strb_a, busy_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: outputs=%h required 0", {dat_a, vld_a, perr_a, ferr_a, brk_a, strb_a, busy_a});
    end
    n_tests++;
    if ({dat_b, vld_b, perr_b, ferr_b, brk_b, strb_b, busy_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: outputs=%h required 0", {dat_b, vld_b, perr_b, ferr_b, brk_b, strb_b, busy_b});
    end
    @(posedge clk); #1 resetn = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_latency();
    int lat;
    bit seen;
    cap_t got, exp;
    lat = -1; seen = 0;
    fork
      send(0, 8'h55, 1'b0, 1'b1, 1'b1);
      begin
        @(posedge clk); #1;
        for (int i = 1; i <= 100 && !seen; i++) begin
          @(posedge clk); @(negedge clk);
          if (vld_a) begin lat = i; seen = 1; end
        end
      end
    join
    model_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, exp);
    get_cap(0, got);
    n_tests++;
    if (lat != EXP_LAT) begin
      n_fail++;
      $display("FAIL latency: rx_valid after %0d cycles, required %0d", lat, EXP_LAT);
    end
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL frame_55: got %h required %h (data,perr,ferr,brk,strb)", got, exp);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_parity();
    cap_t got, exp;
    logic [3:0] pb;
    pb = 4'b0010; // second frame carries the wrong parity bit
    for (int i = 0; i < 4; i++) begin
      do_frame(1, 8'h3C, (^8'h3C) ^ pb[i], 1'b1, 1'b1, got, exp);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL parity[%0d]: got %h required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_stop2();
    cap_t got, exp;
    do_frame(1, 8'h12, ^8'h12, 1'b1, 1'b0, got, exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL stop2_low: got %h required %h", got, exp);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (ferr_b !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_hold: frame_err=%b required 1", ferr_b);
    end
    do_frame(1, 8'h12, ^8'h12, 1'b1, 1'b1, got, exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL stop2_clean: got %h required %h", got, exp);
    end
  endtask

  task automatic test_break();
    cap_t got, exp;
    int nv;
    logic [7:0] d;
    @(posedge clk); #1 rxd_a = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    #1 rxd_a = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    nv = cap_a.size();
    n_tests++;
    if (nv != 1) begin
      n_fail++;
      $display("FAIL break_count: %0d rx_valid pulses, required 1", nv);
    end
    model_frame(0, 8'h00, 1'b0, 1'b0, 1'b0, exp);
    get_cap(0, got);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL break_frame: got %h required %h", got, exp);
    end
    cap_a.delete();
    d = 8'($urandom);
    do_frame(0, d, 1'b0, 1'b1, 1'b1, got, exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL after_break: got %h required %h", got, exp);
    end
  endtask

  task automatic test_cmd();
    cap_t got, exp;
    logic [7:0] seq [7];
    seq = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hA5};
    for (int i = 0; i < 7; i++) begin
      do_frame(0, seq[i], 1'b0, 1'b1, 1'b1, got, exp);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cmd[%0d]: got %h required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    int busy_cnt;
    busy_cnt = 0;
    @(posedge clk); #1 rxd_a = 1'b0;
    @(posedge clk); #1 rxd_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
    end
    n_tests++;
    if (busy_cnt > CPB / 2 + 2) begin
      n_fail++;
      $display("FAIL glitch_busy: busy for %0d cycles, required <= %0d", busy_cnt, CPB / 2 + 2);
    end
    n_tests++;
    if (cap_a.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_valid: %0d rx_valid pulses, required 0", cap_a.size());
    end
  endtask

  task automatic test_rx_en();
    cap_t got, exp;
    logic pre_busy;
    pre_busy = 1'b0;
    fork
      send(0, 8'h5A, 1'b0, 1'b1, 1'b1);
      begin
        repeat (20) @(posedge clk);
        #2 pre_busy = busy_a;
        en_a = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    n_tests++;
    if (pre_busy !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_en_abort: busy before=%b after=%b, required 1 then 0", pre_busy, busy_a);
    end
    n_tests++;
    if (cap_a.size() != 0) begin
      n_fail++;
      $display("FAIL rx_en_valid: %0d rx_valid pulses, required 0", cap_a.size());
    end
    en_a = 1'b1;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      do_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, got, exp);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rx_en_cmd[%0d]: got %h required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    cap_t got, exp;
    logic pre_busy;
    pre_busy = 1'b0;
    fork
      send(0, 8'h3C, 1'b0, 1'b1, 1'b1);
      begin
        repeat (18) @(posedge clk);
        #2 pre_busy = busy_a;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (pre_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL mid_busy: busy=%b before reset, required 1", pre_busy);
        end
        n_tests++;
        if ({dat_a, vld_a, perr_a, ferr_a, brk_a, strb_a, busy_a} !== '0) begin
          n_fail++;
          $display("FAIL async_reset: outputs=%h required 0", {dat_a, vld_a, perr_a, ferr_a, brk_a, strb_a, busy_a});
        end
      end
    join
    cmd_cnt[0] = 0; cmd_cnt[1] = 0;
    cap_a.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    do_frame(0, 8'h81, 1'b0, 1'b1, 1'b1, got, exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL after_reset_81: got %h required %h", got, exp);
    end
  endtask

  task automatic test_random();
    cap_t got, exp;
    int which;
    logic [7:0] d;
    logic pb, s0, s1;
    for (int i = 0; i < 30; i++) begin
      which = $urandom_range(0, 1);
      d = 8'($urandom);
      if ($urandom_range(0, 2) == 0) d = (which == 0) ? 8'hA5 : 8'h3C;
      if ($urandom_range(0, 9) == 0) d = 8'h00;
      pb = (^(d & 8'h7F)) ^ ($urandom_range(0, 4) == 0);
      s0 = ($urandom_range(0, 5) != 0);
      s1 = ($urandom_range(0, 5) != 0);
      do_frame(which, d, pb, s0, s1, got, exp);
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] dut%0d: got %h required %h", i, which, got, exp);
      end
    end
  endtask

  task automatic test_no_stray();
    repeat (5) @(negedge clk);
    n_tests++;
    if (stray != 0 || cap_a.size() != 0 || cap_b.size() != 0) begin
      n_fail++;
      $display("FAIL stray: %0d strobes/breaks outside rx_valid, %0d/%0d extra frames, required 0",
               stray, cap_a.size(), cap_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_parity();
    test_stop2();
    test_break();
    test_cmd();
    test_glitch();
    test_rx_en();
    test_reset_mid();
    test_random();
    test_no_stray();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
